// File: rtl/julia_pixel_scheduler.sv
// rtl/julia_pixel_scheduler.sv - walks a frame of pixel coordinates through an iteration core
//
// Scans an H_RES x V_RES frame in raster order. For each pixel it hands the
// complex coordinate (core_zx_o, core_zy_o) to a downstream iteration core and
// waits for its result. It then streams the iteration count out on a
// valid/ready pixel interface.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   frame_start_i            one-cycle frame request (honoured only when idle)
//   x_min_i, y_max_i, step_i frame origin (column 0 real, row 0 imaginary) and step
//   core_start_o             one-cycle start pulse to the core
//   core_zx_o, core_zy_o     coordinate presented to the core
//   core_done_i, core_iter_i core result; done is level-held until the next start
//   pix_valid_o, pix_ready_i result stream handshake
//   pix_iter_o, pix_last_o   iteration count, last-pixel-of-frame flag
//   pix_col_o, pix_row_o     pixel position (only with JULIA_SCHED_COORD_EN)
//   busy_o                   high while a frame is in progress
//   frame_done_o             one-cycle pulse after the last pixel is accepted
//
// Optional feature macro: JULIA_SCHED_COORD_EN adds pix_col_o / pix_row_o.

`timescale 1ns/1ps

module julia_pixel_scheduler #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16,
    localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS,
    localparam int COL_W          = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int ROW_W          = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic [DATA_WIDTH-1:0]     x_min_i,
    input  logic [DATA_WIDTH-1:0]     y_max_i,
    input  logic [DATA_WIDTH-1:0]     step_i,
    output logic                      core_start_o,
    output logic [DATA_WIDTH-1:0]     core_zx_o,
    output logic [DATA_WIDTH-1:0]     core_zy_o,
    input  logic                      core_done_i,
    input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
    output logic                      pix_valid_o,
    input  logic                      pix_ready_i,
    output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
    output logic                      pix_last_o,
`ifdef JULIA_SCHED_COORD_EN
    output logic [COL_W-1:0]          pix_col_o,
    output logic [ROW_W-1:0]          pix_row_o,
`endif
    output logic                      busy_o,
    output logic                      frame_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                state;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] zx;
    logic [DATA_WIDTH-1:0] zy;
    logic [DATA_WIDTH-1:0] x_min_q;
    logic [DATA_WIDTH-1:0] y_max_q;
    logic [DATA_WIDTH-1:0] step_q;

    logic col_end;
    logic last_pos;

    assign col_end  = (col == COL_W'(H_RES - 1));
    assign last_pos = col_end && (row == ROW_W'(V_RES - 1));

    // zx/zy only move on the output handshake, so the core sees a stable
    // coordinate from ISSUE through WAIT.
    assign core_zx_o = zx;
    assign core_zy_o = zy;

`ifdef JULIA_SCHED_COORD_EN
    assign pix_col_o = col;
    assign pix_row_o = row;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            zx           <= '0;
            zy           <= '0;
            x_min_q      <= '0;
            y_max_q      <= '0;
            step_q       <= '0;
            core_start_o <= 1'b0;
            pix_valid_o  <= 1'b0;
            pix_iter_o   <= '0;
            pix_last_o   <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            core_start_o <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        x_min_q      <= x_min_i;
                        y_max_q      <= y_max_i;
                        step_q       <= step_i;
                        col          <= '0;
                        row          <= '0;
                        zx           <= x_min_i;
                        zy           <= y_max_i;
                        core_start_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // core_done_i deliberately ignored here: it may still be
                    // the level-held answer for the previous pixel.
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done_i) begin
                        pix_iter_o  <= core_iter_i;
                        pix_last_o  <= last_pos;
                        pix_valid_o <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (pix_ready_i) begin
                        pix_valid_o <= 1'b0;
                        pix_last_o  <= 1'b0;
                        if (last_pos) begin
                            // Park the position back at the frame origin.
                            col          <= '0;
                            row          <= '0;
                            zx           <= x_min_q;
                            zy           <= y_max_q;
                            busy_o       <= 1'b0;
                            frame_done_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            if (col_end) begin
                                col <= '0;
                                zx  <= x_min_q;
                                row <= row + ROW_W'(1);
                                zy  <= zy - step_q;
                            end else begin
                                col <= col + COL_W'(1);
                                zx  <= zx + step_q;
                            end
                            core_start_o <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// tb/tb_julia_pixel_scheduler.sv - self-checking bench for julia_pixel_scheduler

`timescale 1ns/1ps

module tb_julia_pixel_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int DW = 32;
    localparam int IW = 16;

    localparam logic [DW-1:0] FX_M2P0 = 32'hFE00_0000;
    localparam logic [DW-1:0] FX_M1P5 = 32'hFE80_0000;
    localparam logic [DW-1:0] FX_M1P0 = 32'hFF00_0000;
    localparam logic [DW-1:0] FX_M0P5 = 32'hFF80_0000;
    localparam logic [DW-1:0] FX_1P0  = 32'h0100_0000;
    localparam logic [DW-1:0] FX_0P5  = 32'h0080_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [DW-1:0] x_min = '0, y_max = '0, step = '0;
    logic          core_start;
    logic [DW-1:0] core_zx, core_zy;
    logic          core_done = 1'b0;
    logic [IW-1:0] core_iter = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [IW-1:0] pix_iter;
    logic          pix_last;
    logic          busy, frame_done;
`ifdef JULIA_SCHED_COORD_EN
    logic [1:0]    pix_col;
    logic [0:0]    pix_row;
`endif

    always #5 clk = ~clk;

    julia_pixel_scheduler #(.H_RES(H), .V_RES(V)) dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
        .x_min_i(x_min), .y_max_i(y_max), .step_i(step),
        .core_start_o(core_start), .core_zx_o(core_zx), .core_zy_o(core_zy),
        .core_done_i(core_done), .core_iter_i(core_iter),
        .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .pix_iter_o(pix_iter), .pix_last_o(pix_last),
`ifdef JULIA_SCHED_COORD_EN
        .pix_col_o(pix_col), .pix_row_o(pix_row),
`endif
        .busy_o(busy), .frame_done_o(frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- core model ----------------
    logic [DW-1:0] cfg_xmin, cfg_ymax, cfg_step;
    bit            hash_mode  = 1'b0;
    bit            stale_hold = 1'b0;
    int            core_lat   = 2;
    int            cnt        = 0;
    bit            pend_clr   = 1'b0;
    logic [DW-1:0] seen_zx = '0, seen_zy = '0;
    int            starts = 0;
    int            fdones = 0;

    function automatic logic [IW-1:0] core_answer(input logic [DW-1:0] zx, input logic [DW-1:0] zy);
        longint c, r;
        if (hash_mode)
            return zx[IW-1:0] ^ zy[DW-1 -: IW] ^ 16'h5a5a;
        c = (longint'($signed(zx)) - longint'($signed(cfg_xmin))) / longint'($signed(cfg_step));
        r = (longint'($signed(cfg_ymax)) - longint'($signed(zy))) / longint'($signed(cfg_step));
        return IW'(c + r);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            cnt = 0; pend_clr = 1'b0; core_done = 1'b0; core_iter = '0;
        end else begin
            if (frame_done) fdones++;
            if (core_start) begin
                starts++;
                seen_zx = core_zx;
                seen_zy = core_zy;
                cnt = core_lat;
                if (stale_hold) pend_clr = 1'b1;
                else core_done = 1'b0;
            end else begin
                if (pend_clr) begin core_done = 1'b0; pend_clr = 1'b0; end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done = 1'b1;
                        core_iter = core_answer(seen_zx, seen_zy);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic start_frame(input logic [DW-1:0] xm, input logic [DW-1:0] ym, input logic [DW-1:0] st);
        cfg_xmin = xm; cfg_ymax = ym; cfg_step = st;
        x_min = xm; y_max = ym; step = st;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_pixel(input logic [DW-1:0] ezx, input logic [DW-1:0] ezy, input logic [IW-1:0] eiter,
                            input bit elast, input int col, input int row, input int rdly, input bit strict);
        int n = 0;
        int s0;
        while (!pix_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pix_valid) begin
            total++; bad++;
            $display("FAIL pix_valid_timeout: got 0 expected 1 at %0t", $time);
            return;
        end
        chk("core_zx_issued", seen_zx, ezx);
        chk("core_zy_issued", seen_zy, ezy);
        chk("core_zx_held", core_zx, ezx);
        chk("pix_iter", pix_iter, eiter);
        chk("pix_last", pix_last, elast);
`ifdef JULIA_SCHED_COORD_EN
        chk("pix_col", pix_col, col);
        chk("pix_row", pix_row, row);
`else
        if (col < 0 || row < 0) $display("bad position argument");
`endif
        s0 = starts;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            if (strict) begin
                chk("stall_valid", pix_valid, 1'b1);
                chk("stall_iter", pix_iter, eiter);
                chk("stall_zx", core_zx, ezx);
                chk("stall_zy", core_zy, ezy);
            end
        end
        if (strict) chk("stall_no_start", starts - s0, 0);
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] zx;
        logic [DW-1:0] zy;
        logic [IW-1:0] iter;
        bit            last;
        int            rdly;
    } vec_t;

    vec_t tbl[8];

    task automatic run_table(input bit mid_start);
        for (int i = 0; i < 8; i++) begin
            if (mid_start && i == 4) begin
                x_min = 32'h0000_0000; y_max = 32'h0000_0000; step = 32'h0100_0000;
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
            do_pixel(tbl[i].zx, tbl[i].zy, tbl[i].iter, tbl[i].last, i % H, i / H,
                     tbl[i].rdly, tbl[i].rdly == 10);
        end
    endtask

    task automatic frame_tail(input string tag, input int fd0, input int st0);
        repeat (3) @(negedge clk);
        chk({tag, "_frame_done_pulses"}, fdones - fd0, 1);
        chk({tag, "_core_starts"}, starts - st0, 8);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_valid_after"}, pix_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, st0;
        logic [DW-1:0] xm, ym, st;

        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] zxs[4];
            zxs[0] = FX_M2P0; zxs[1] = FX_M1P5; zxs[2] = FX_M1P0; zxs[3] = FX_M0P5;
            tbl[i].zx   = zxs[i % 4];
            tbl[i].zy   = (i < 4) ? FX_1P0 : FX_0P5;
            tbl[i].iter = IW'((i % 4) + (i / 4));
            tbl[i].last = (i == 7);
            tbl[i].rdly = (i == 3) ? 10 : (i % 3);
        end

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_last", pix_last, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_core_zx", core_zx, 0);
        chk("rst_core_zy", core_zy, 0);
        chk("rst_pix_iter", pix_iter, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed frame with a 10-cycle stall on pixel 3
        fd0 = fdones; st0 = starts;
        start_frame(FX_M2P0, FX_1P0, FX_0P5);
        chk("A_busy_issue", busy, 1'b1);
        chk("A_core_start_issue", core_start, 1'b1);
        run_table(1'b0);
        frame_tail("A", fd0, st0);

        // stale done held through ISSUE, plus frame_start mid-frame
        stale_hold = 1'b1;
        fd0 = fdones; st0 = starts;
        start_frame(FX_M2P0, FX_1P0, FX_0P5);
        run_table(1'b1);
        frame_tail("B", fd0, st0);
        stale_hold = 1'b0;

        // reset during WAIT of pixel 3, then restart immediately
        start_frame(FX_M2P0, FX_1P0, FX_0P5);
        for (int i = 0; i < 2; i++)
            do_pixel(tbl[i].zx, tbl[i].zy, tbl[i].iter, tbl[i].last, i, 0, 0, 1'b0);
        do_pixel(tbl[2].zx, tbl[2].zy, tbl[2].iter, tbl[2].last, 2, 0, 0, 1'b0);
        @(negedge clk);
        chk("C_in_wait_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("C_rst_busy", busy, 1'b0);
        chk("C_rst_core_start", core_start, 1'b0);
        chk("C_rst_pix_valid", pix_valid, 1'b0);
        chk("C_rst_core_zx", core_zx, 0);
        chk("C_rst_core_zy", core_zy, 0);
        chk("C_rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        fd0 = fdones; st0 = starts;
        rst = 1'b0;
        start_frame(FX_M2P0, FX_1P0, FX_0P5);
        for (int i = 0; i < 8; i++)
            do_pixel(tbl[i].zx, tbl[i].zy, tbl[i].iter, tbl[i].last, i % H, i / H, 0, 1'b0);
        frame_tail("C", fd0, st0);

        // randomized frames against a coordinate-arithmetic reference
        hash_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            xm = $urandom; ym = $urandom; st = $urandom;
            core_lat = $urandom_range(1, 4);
            fd0 = fdones; st0 = starts;
            start_frame(xm, ym, st);
            for (int r = 0; r < V; r++) begin
                for (int c = 0; c < H; c++) begin
                    logic [DW-1:0] ezx, ezy;
                    ezx = xm + DW'(c) * st;
                    ezy = ym - DW'(r) * st;
                    do_pixel(ezx, ezy, core_answer(ezx, ezy), (c == H-1) && (r == V-1),
                             c, r, $urandom_range(0, 3), 1'b0);
                end
            end
            frame_tail("R", fd0, st0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/julia_pixel_scheduler.md
JULIA_PIXEL_SCHEDULER -- requirements
Module: julia_pixel_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per row.
REQ-002 SHALL have parameter V_RES, default 480, rows per frame.
REQ-003 SHALL have parameters INTEGER_BITS 8, FRACTIONAL_BITS 24 and MAX_ITER_WIDTH 16, with DATA_WIDTH = INTEGER_BITS+FRACTIONAL_BITS, all signed fixed-point.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port frame_start_i, input, 1 bit: a one-cycle frame request.
REQ-007 SHALL have ports x_min_i and y_max_i, input, DATA_WIDTH bits each: the real part of column 0 and the imaginary part of row 0.
REQ-008 SHALL have port step_i, input, DATA_WIDTH bits: the per-pixel coordinate increment, with the same step used for both axes.
REQ-009 SHALL have ports core_start_o (output, 1 bit) and core_zx_o / core_zy_o (output, DATA_WIDTH bits each): the request to the downstream iteration core.
REQ-010 SHALL have ports core_done_i (input, 1 bit) and core_iter_i (input, MAX_ITER_WIDTH bits): the core's result, with done level-held until the next start.
REQ-011 SHALL have ports pix_valid_o (output, 1 bit), pix_ready_i (input, 1 bit), pix_iter_o (output, MAX_ITER_WIDTH bits) and pix_last_o (output, 1 bit): the result stream.
REQ-012 SHALL have ports busy_o (output, 1 bit, high while a frame is in progress) and frame_done_o (output, 1 bit, one-cycle pulse).

Function
REQ-013 SHALL implement a state machine with states IDLE, ISSUE, WAIT and OUTPUT.
REQ-014 SHALL, in IDLE on frame_start_i=1, latch x_min_i, y_max_i and step_i, set col=0, row=0, zx=x_min and zy=y_max, and go to ISSUE.
REQ-015 SHALL ignore frame_start_i in every state other than IDLE.
REQ-016 SHALL drive core_start_o high for exactly one cycle in ISSUE, then go to WAIT; core_zx_o and core_zy_o SHALL be stable from ISSUE through WAIT.
REQ-017 SHALL, in WAIT, sample core_done_i only, never in ISSUE, so that a stale done from the previous pixel is never accepted.
REQ-018 SHALL, on core_done_i=1 in WAIT, register core_iter_i into pix_iter_o and go to OUTPUT.
REQ-019 SHALL hold pix_valid_o=1 in OUTPUT, with pix_iter_o and pix_last_o stable, until pix_ready_i=1.
REQ-020 SHALL drive pix_last_o=1 only when col=H_RES-1 and row=V_RES-1.
REQ-021 SHALL advance position on the OUTPUT handshake (pix_valid_o & pix_ready_i):
  - col<H_RES-1: col+1, zx+=step.
  - otherwise: col=0, zx=x_min, row+1, zy-=step.
REQ-022 SHALL, on the handshake of the last pixel, go to IDLE and pulse frame_done_o high for one cycle; otherwise it SHALL go to ISSUE.
REQ-023 SHALL wrap fixed-point zx/zy additions modulo 2^DATA_WIDTH, with no saturation.
REQ-024 SHALL hold busy_o=1 in ISSUE, WAIT and OUTPUT, and busy_o=0 in IDLE.
REQ-025 SHALL give a minimum per-pixel latency of ISSUE→WAIT(≥1)→OUTPUT(≥1), i.e. 3 cycles plus core time.

Reset
REQ-026 SHALL, while rst_i=1, immediately force IDLE, with all outputs 0 and col, row, zx, zy and the latched config all 0.
REQ-027 SHALL, on reset mid-frame, abandon the frame: emit no further pixel and no frame_done_o pulse, and accept a new frame_start_i on the first cycle after reset release.

Configuration
REQ-028 SHALL, when JULIA_SCHED_COORD_EN is defined, add outputs pix_col_o (clog2(H_RES) bits) and pix_row_o (clog2(V_RES) bits), giving the position of the current pixel and held stable with pix_iter_o.
REQ-029 SHALL, when JULIA_SCHED_COORD_EN is undefined, omit those ports, with all other behaviour identical.

Verification
REQ-030 SHALL cover: H_RES=4, V_RES=2, x_min=-2.0, y_max=1.0, step=0.5, core model answering done after 2 cycles with iter=col+row → 8 pixels in the order 0,1,2,3,1,2,3,4, pix_last_o only on the 8th, one frame_done_o pulse.
REQ-031 SHALL cover: the same frame with the core_zx_o/core_zy_o sequence checked → -2.0,-1.5,-1.0,-0.5 at 1.0, then -2.0..-0.5 at 0.5.
REQ-032 SHALL cover: pix_ready_i held low for 10 cycles in OUTPUT → pix_valid_o and pix_iter_o stable, no core_start_o, position unchanged.
REQ-033 SHALL cover: core_done_i held high (stale) during ISSUE → not accepted; the result is taken only after a fresh done in WAIT.
REQ-034 SHALL cover: frame_start_i pulsed mid-frame → ignored, pixel count still 8.
REQ-035 SHALL cover: rst_i asserted during WAIT of pixel 3 → all outputs 0 at once, busy_o=0, and a new frame restarts at col 0 / row 0 with zx=x_min.
